// File: rtl/booth_seq_mult_pkg.sv
// ============================================================================
// booth_seq_mult_pkg : shared FSM encoding and radix-dependent sizing helpers
//   Build option: BOOTH_RADIX4_EN selects radix-4 modified Booth stepping.
// Revision: 1.0
// ============================================================================
`default_nettype none

package booth_seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

`ifdef BOOTH_RADIX4_EN
    localparam int c_SHIFT = 2;
    localparam int c_WIN_W = 3;

    // Extended width rounded up to even so the 2-bit windows tile it exactly.
    function automatic int ew_of(input int width);
        return ((width + 3) / 2) * 2;
    endfunction

    function automatic int iter_of(input int width);
        return ew_of(width) / 2;
    endfunction
`else
    localparam int c_SHIFT = 1;
    localparam int c_WIN_W = 2;

    function automatic int ew_of(input int width);
        return width + 1;
    endfunction

    function automatic int iter_of(input int width);
        return width + 1;
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/booth_seq_mult_recode.sv
// ============================================================================
// booth_seq_mult_recode : maps a Booth window onto a signed addend (0, +-M, +-2M)
//   Build option: BOOTH_RADIX4_EN widens the window to three bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module booth_seq_mult_recode
    import booth_seq_mult_pkg::*;
#(
    parameter int EW = 33
) (
    input  logic [c_WIN_W-1:0] window,
    input  logic [EW-1:0]      mcand,
    output logic [EW:0]        addend
);

    logic [EW:0] w_m;

    assign w_m = {mcand[EW-1], mcand};

`ifdef BOOTH_RADIX4_EN
    logic [EW:0] w_m2;

    assign w_m2 = {mcand, 1'b0};

    always_comb begin
        addend = '0;
        case (window)
            3'b001, 3'b010: addend = w_m;
            3'b011:         addend = w_m2;
            3'b100:         addend = -w_m2;
            3'b101, 3'b110: addend = -w_m;
            default:        addend = '0;
        endcase
    end
`else
    always_comb begin
        addend = '0;
        case (window)
            2'b01:   addend = w_m;
            2'b10:   addend = -w_m;
            default: addend = '0;
        endcase
    end
`endif

endmodule

`default_nettype wire

// File: rtl/booth_seq_mult.sv
// ============================================================================
// booth_seq_mult : sequential Booth multiplier, one step per clock, start/busy/done
//   Build option: BOOTH_RADIX4_EN selects radix-4 (fewer steps, same results).
// Revision: 1.0
// ============================================================================
`default_nettype none

module booth_seq_mult
    import booth_seq_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_EW   = ew_of(WIDTH);
    localparam int c_ITER = iter_of(WIDTH);
    localparam int c_CW   = $clog2(c_ITER + 1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_accept;
    logic                 w_last;

    logic [c_CW-1:0]      r_count;
    logic [c_EW:0]        r_acc;
    logic [c_EW-1:0]      r_q;
    logic                 r_q1;
    logic [c_EW-1:0]      r_mcand;
    logic [2*WIDTH-1:0]   r_product;

    logic [c_EW-1:0]      w_m_ext;
    logic [c_EW-1:0]      w_q_ext;
    logic [c_WIN_W-1:0]   w_window;
    logic [c_EW:0]        w_addend;
    logic [c_EW:0]        w_sum;
    logic [2*c_EW+1:0]    w_shifted;

    // Unsigned mode simply forces the extension bits to zero.
    assign w_m_ext = {{(c_EW-WIDTH){is_signed & multiplicand[WIDTH-1]}}, multiplicand};
    assign w_q_ext = {{(c_EW-WIDTH){is_signed & multiplier[WIDTH-1]}}, multiplier};

`ifdef BOOTH_RADIX4_EN
    assign w_window = {r_q[1:0], r_q1};
`else
    assign w_window = {r_q[0], r_q1};
`endif

    booth_seq_mult_recode #(
        .EW (c_EW)
    ) u_recode (
        .window (w_window),
        .mcand  (r_mcand),
        .addend (w_addend)
    );

    assign w_sum     = r_acc + w_addend;
    assign w_shifted = $signed({w_sum, r_q, r_q1}) >>> c_SHIFT;
    assign w_last    = (r_count == c_CW'(1));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_mcand   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_count   <= c_CW'(c_ITER);
            r_acc     <= '0;
            r_q       <= w_q_ext;
            r_q1      <= 1'b0;
            r_mcand   <= w_m_ext;
        end else if (r_state == ST_RUN) begin
            r_count   <= r_count - c_CW'(1);
            r_acc     <= w_shifted[2*c_EW+1:c_EW+1];
            r_q       <= w_shifted[c_EW:1];
            r_q1      <= w_shifted[0];
            // The final shift leaves the full product in {acc, Q}.
            if (w_last) begin
                r_product <= w_shifted[2*WIDTH:1];
            end
        end
    end

    assign product = r_product;

endmodule

`default_nettype wire
